// File: rtl/tt_um_fpu.sv
// tt_um_fpu: FP8 E4M3 (bias 7) minifloat FPU tile.
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst_n    synchronous active-low reset
//   ena      tile enable; commands are ignored while low
//   ui_in    operand byte for LOAD_A / LOAD_B
//   uio_in   [1:0] cmd (NOP/LOAD_A/LOAD_B/EXEC), [3:2] op (ADD/SUB/MUL/MAX)
//   uo_out   registered result
//   uio_out  [7:4] flags {NV,OF,UF,NX}, [3:0] zero
//   uio_oe   constant 8'hF0
// Build option: define FPU_SUBNORMAL_EN to handle subnormal inputs and
// outputs; otherwise exponent-0 values are flushed to signed zero.
module tt_um_fpu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {CMD_NOP, CMD_LOAD_A, CMD_LOAD_B, CMD_EXEC} cmd_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_MAX} op_e;

  localparam logic [7:0] QNAN = 8'h7F;

  logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0] flg_q, flg_d;
  logic [7:0] ex_res;
  logic [3:0] ex_flg;
  cmd_e       cmd;
  op_e        op;
  logic       unused_uio;

  assign cmd        = cmd_e'(uio_in[1:0]);
  assign op         = op_e'(uio_in[3:2]);
  assign unused_uio = &{1'b0, uio_in[7:4]};

  // Right shift that ORs every bit shifted out into bit 0 (sticky).
  function automatic logic [11:0] shr_jam(input logic [11:0] v, input logic [7:0] n);
    logic [11:0] r;
    r = v;
    for (int unsigned i = 0; i < 16; i++)
      if (8'(i) < n) r = {1'b0, r[11:2], r[1] | r[0]};
    return r;
  endfunction

  // Normalize, round RNE and pack. sig has its binary point between bits
  // 10 and 9 (bit 11 is carry headroom); e is the biased exponent.
  // Returns {result[7:0], OF, UF, NX}.
  function automatic logic [10:0] round_pack(input logic s, input logic signed [7:0] e_in,
                                             input logic [11:0] sig_in);
    logic [11:0]       sig;
    logic signed [7:0] e;
    logic [3:0]        lz;
    logic [4:0]        r;
    logic              inexact, up, of, uf, nx;
    logic [7:0]        res;
`ifdef FPU_SUBNORMAL_EN
    logic              tiny;
`endif
    sig = sig_in;
    e   = e_in;
    lz  = '0;
    if (sig[11]) begin
      sig = shr_jam(sig, 8'd1);
      e   = e + 8'sd1;
    end else begin
      for (int unsigned i = 0; i < 11; i++)
        if (sig[i]) lz = 4'(10 - i);
      sig = sig << lz;
      e   = e - $signed({4'b0, lz});
    end
`ifdef FPU_SUBNORMAL_EN
    tiny = (e < 8'sd1);
    if (tiny) begin
      sig = shr_jam(sig, 8'(8'sd1 - e));
      e   = 8'sd1;
    end
`endif
    inexact = sig[6] | (|sig[5:0]);
    up      = sig[6] & (sig[7] | (|sig[5:0]));
    r       = {1'b0, sig[10:7]} + {4'b0, up};
    if (r[4]) begin
      r = 5'b01000;
      e = e + 8'sd1;
    end
    of  = 1'b0;
    uf  = 1'b0;
    nx  = inexact;
    // A cleared hidden bit can only occur for subnormal results.
    res = {s, (r[3] ? e[3:0] : 4'd0), r[2:0]};
    if (e > 8'sd14) begin
      res = {s, 7'h78};
      of  = 1'b1;
      nx  = 1'b1;
    end
`ifdef FPU_SUBNORMAL_EN
    else uf = tiny & inexact;
`else
    else if (e < 8'sd1) begin
      res = {s, 7'h00};
      uf  = 1'b1;
      nx  = 1'b1;
    end
`endif
    return {res, of, uf, nx};
  endfunction

  // Greater-or-equal on sign-magnitude encodings; +0 beats -0.
  function automatic logic ge(input logic [7:0] x, input logic [7:0] y);
    if (x[7] != y[7]) return ~x[7];
    else if (!x[7])   return x[6:0] >= y[6:0];
    else              return x[6:0] <= y[6:0];
  endfunction

  logic              sa, sb, sbx, sx, sl, ss, za, zb, ia, ib, na, nb, a_big;
  logic [3:0]        ea, eb, el, es, siga, sigb, sigl, sigs;
  logic [7:0]        ac, bc, prod;
  logic [11:0]       al_big, al_small, sum;
  logic signed [7:0] emul;
  logic [10:0]       rp;

  always_comb begin
    sa   = a_q[7];
    sb   = b_q[7];
    na   = (a_q[6:3] == 4'hF) && (a_q[2:0] != 3'd0);
    nb   = (b_q[6:3] == 4'hF) && (b_q[2:0] != 3'd0);
    ia   = (a_q[6:0] == 7'h78);
    ib   = (b_q[6:0] == 7'h78);
`ifdef FPU_SUBNORMAL_EN
    za   = (a_q[6:0] == 7'h00);
    zb   = (b_q[6:0] == 7'h00);
`else
    za   = (a_q[6:3] == 4'h0);
    zb   = (b_q[6:3] == 4'h0);
`endif
    ea   = (a_q[6:3] == 4'h0) ? 4'd1 : a_q[6:3];
    eb   = (b_q[6:3] == 4'h0) ? 4'd1 : b_q[6:3];
    siga = {a_q[6:3] != 4'h0, a_q[2:0]};
    sigb = {b_q[6:3] != 4'h0, b_q[2:0]};
    ac   = za ? {sa, 7'h00} : a_q;
    bc   = zb ? {sb, 7'h00} : b_q;

    // Add path: order by magnitude so the difference is never negative.
    sbx      = sb ^ (op == OP_SUB);
    a_big    = (a_q[6:0] >= b_q[6:0]);
    sl       = a_big ? sa : sbx;
    ss       = a_big ? sbx : sa;
    el       = a_big ? ea : eb;
    es       = a_big ? eb : ea;
    sigl     = a_big ? siga : sigb;
    sigs     = a_big ? sigb : siga;
    al_big   = {1'b0, sigl, 7'b0};
    al_small = shr_jam({1'b0, sigs, 7'b0}, {4'b0, el - es});
    sum      = (sl == ss) ? al_big + al_small : al_big - al_small;

    // Mul path: 1.3 x 1.3 gives 2.6, placed with the same binary point.
    sx   = sa ^ sb;
    prod = {4'b0, siga} * {4'b0, sigb};
    emul = $signed({4'b0, ea} + {4'b0, eb} - 8'd7);

    // One rounder shared by ADD/SUB and MUL.
    rp = (op == OP_MUL) ? round_pack(sx, emul, {prod, 4'b0})
                        : round_pack(sl, $signed({4'b0, el}), sum);

    ex_res = QNAN;
    ex_flg = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        if (na | nb)          ex_res = QNAN;
        else if (ia & ib) begin
          if (sa == sbx)      ex_res = {sa, 7'h78};
          else                ex_flg = 4'b1000;
        end
        else if (ia)          ex_res = {sa, 7'h78};
        else if (ib)          ex_res = {sbx, 7'h78};
        else if (za & zb)     ex_res = {sa & sbx, 7'h00};
        else if (za)          ex_res = {sbx, b_q[6:0]};
        else if (zb)          ex_res = {sa, a_q[6:0]};
        else if (sum == '0)   ex_res = 8'h00;
        else                  {ex_res, ex_flg[2:0]} = rp;
      end
      OP_MUL: begin
        if (na | nb)                      ex_res = QNAN;
        else if ((ia & zb) | (za & ib))   ex_flg = 4'b1000;
        else if (ia | ib)                 ex_res = {sx, 7'h78};
        else if (za | zb)                 ex_res = {sx, 7'h00};
        else                              {ex_res, ex_flg[2:0]} = rp;
      end
      default: begin
        if (na & nb)          ex_res = QNAN;
        else if (na)          ex_res = bc;
        else if (nb)          ex_res = ac;
        else if (ge(ac, bc))  ex_res = ac;
        else                  ex_res = bc;
      end
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    flg_d = flg_q;
    if (ena) begin
      case (cmd)
        CMD_LOAD_A: a_d = ui_in;
        CMD_LOAD_B: b_d = ui_in;
        CMD_EXEC: begin
          res_d = ex_res;
          flg_d = ex_flg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  assign uo_out  = res_q;
  assign uio_out = {flg_q, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_fpu.sv
module tb_tt_um_fpu;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int total = 0;
  int bad = 0;

  localparam logic [1:0] NOP = 2'd0, LDA = 2'd1, LDB = 2'd2, EXE = 2'd3;
  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, MAX = 2'd3;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] r;
    logic [3:0] f;  // {NV,OF,UF,NX}
  } vec_t;

  tt_um_fpu dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // One clock with the given command; upper uio_in bits carry junk.
  task automatic step(input logic [1:0] cmd, input logic [1:0] op, input logic [7:0] d);
    ui_in  = d;
    uio_in = {4'h5, op, cmd};
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    step(LDA, ADD, a);
    step(LDB, ADD, b);
    step(EXE, op, 8'h00);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ena   = 1'b1;
    step(EXE, ADD, 8'h00);
    step(EXE, ADD, 8'h00);
    total++;
    if (uo_out !== 8'h00) begin
      bad++; $display("FAIL reset_uo got=%h exp=00", uo_out);
    end
    total++;
    if (uio_out !== 8'h00) begin
      bad++; $display("FAIL reset_uio got=%h exp=00", uio_out);
    end
    total++;
    if (uio_oe !== 8'hF0) begin
      bad++; $display("FAIL reset_oe got=%h exp=f0", uio_oe);
    end
    rst_n = 1'b1;
    step(NOP, ADD, 8'h00);
  endtask

  task automatic test_add_enable;
    run_op(8'h38, 8'h38, ADD);
    total++;
    if ({uo_out, uio_out} !== {8'h40, 8'h00}) begin
      bad++; $display("FAIL add_1p1 got=%h_%h exp=40_00", uo_out, uio_out);
    end
    step(LDA, ADD, 8'h40);
    step(LDB, ADD, 8'h40);
    total++;
    if ({uo_out, uio_out} !== {8'h40, 8'h00}) begin
      bad++; $display("FAIL load_holds got=%h_%h exp=40_00", uo_out, uio_out);
    end
    ena = 1'b0;
    step(EXE, ADD, 8'h00);
    total++;
    if ({uo_out, uio_out} !== {8'h40, 8'h00}) begin
      bad++; $display("FAIL ena_exec got=%h_%h exp=40_00", uo_out, uio_out);
    end
    step(LDA, ADD, 8'h00);
    ena = 1'b1;
    step(EXE, ADD, 8'h00);
    total++;
    if ({uo_out, uio_out} !== {8'h48, 8'h00}) begin
      bad++; $display("FAIL ena_load got=%h_%h exp=48_00", uo_out, uio_out);
    end
  endtask

  task automatic test_rounding;
    vec_t v[4];
    v = '{'{8'h38, 8'h1C, ADD, 8'h39, 4'b0001},
          '{8'h38, 8'h18, ADD, 8'h38, 4'b0001},
          '{8'h3C, 8'h3C, MUL, 8'h41, 4'b0000},
          '{8'h40, 8'h3F, SUB, 8'h20, 4'b0000}};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].a, v[i].b, v[i].op);
      total++;
      if ({uo_out, uio_out} !== {v[i].r, v[i].f, 4'h0}) begin
        bad++;
        $display("FAIL round[%0d] got=%h_%h exp=%h_%h", i, uo_out, uio_out, v[i].r, {v[i].f, 4'h0});
      end
    end
  endtask

  task automatic test_exceptions;
    vec_t v[8];
    logic [7:0] uf_r;
    logic [3:0] uf_f;
`ifdef FPU_SUBNORMAL_EN
    uf_r = 8'h04; uf_f = 4'b0000;
`else
    uf_r = 8'h00; uf_f = 4'b0011;
`endif
    v = '{'{8'h77, 8'h40, MUL, 8'h78, 4'b0101},
          '{8'h78, 8'h78, SUB, 8'h7F, 4'b1000},
          '{8'h00, 8'hF8, MUL, 8'h7F, 4'b1000},
          '{8'h38, 8'hB8, ADD, 8'h00, 4'b0000},
          '{8'h80, 8'h80, ADD, 8'h80, 4'b0000},
          '{8'h78, 8'h38, ADD, 8'h78, 4'b0000},
          '{8'h7F, 8'h38, ADD, 8'h7F, 4'b0000},
          '{8'h08, 8'h30, MUL, uf_r, uf_f}};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].a, v[i].b, v[i].op);
      total++;
      if ({uo_out, uio_out} !== {v[i].r, v[i].f, 4'h0}) begin
        bad++;
        $display("FAIL exc[%0d] got=%h_%h exp=%h_%h", i, uo_out, uio_out, v[i].r, {v[i].f, 4'h0});
      end
    end
  endtask

  task automatic test_max;
    vec_t v[5];
    v = '{'{8'h80, 8'h00, MAX, 8'h00, 4'b0000},
          '{8'h7F, 8'hC0, MAX, 8'hC0, 4'b0000},
          '{8'hB8, 8'h38, MAX, 8'h38, 4'b0000},
          '{8'hC0, 8'hB8, MAX, 8'hB8, 4'b0000},
          '{8'h7F, 8'h7F, MAX, 8'h7F, 4'b0000}};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].a, v[i].b, v[i].op);
      total++;
      if ({uo_out, uio_out} !== {v[i].r, v[i].f, 4'h0}) begin
        bad++;
        $display("FAIL max[%0d] got=%h_%h exp=%h_%h", i, uo_out, uio_out, v[i].r, {v[i].f, 4'h0});
      end
    end
  endtask

  task automatic test_back_to_back;
    run_op(8'h40, 8'h38, SUB);
    total++;
    if ({uo_out, uio_out} !== {8'h38, 8'h00}) begin
      bad++; $display("FAIL b2b_sub got=%h_%h exp=38_00", uo_out, uio_out);
    end
    step(EXE, MUL, 8'h00);
    total++;
    if ({uo_out, uio_out} !== {8'h40, 8'h00}) begin
      bad++; $display("FAIL b2b_mul got=%h_%h exp=40_00", uo_out, uio_out);
    end
    step(EXE, ADD, 8'h00);
    total++;
    if ({uo_out, uio_out} !== {8'h44, 8'h00}) begin
      bad++; $display("FAIL b2b_add got=%h_%h exp=44_00", uo_out, uio_out);
    end
    // Flags must be overwritten, not accumulated.
    run_op(8'h77, 8'h40, MUL);
    step(EXE, MAX, 8'h00);
    total++;
    if ({uo_out, uio_out} !== {8'h77, 8'h00}) begin
      bad++; $display("FAIL flags_clear got=%h_%h exp=77_00", uo_out, uio_out);
    end
  endtask

  task automatic test_reset_wins;
    run_op(8'h38, 8'h40, ADD);
    rst_n = 1'b0;
    step(EXE, ADD, 8'h00);
    total++;
    if ({uo_out, uio_out} !== {8'h00, 8'h00}) begin
      bad++; $display("FAIL rst_wins got=%h_%h exp=00_00", uo_out, uio_out);
    end
    rst_n = 1'b1;
    step(LDA, ADD, 8'h38);
    step(EXE, ADD, 8'h00);
    total++;
    if ({uo_out, uio_out} !== {8'h38, 8'h00}) begin
      bad++; $display("FAIL rst_b_clear got=%h_%h exp=38_00", uo_out, uio_out);
    end
  endtask

  initial begin
    test_reset();
    test_add_enable();
    test_rounding();
    test_exceptions();
    test_max();
    test_back_to_back();
    test_reset_wins();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_fpu.md
Name: tt_um_fpu

Overview:
- Tiny 8-bit minifloat FPU tile for the TinyTapeout harness.
- Format: FP8 E4M3, IEEE-style. Sign bit 7, exponent bits 6:3 with bias 7, mantissa bits 2:0; exponent 15 encodes Inf/NaN.
- Operands A and B are loaded byte-serially through ui_in under command control from uio_in.
- An execute command computes ADD, SUB, MUL or MAX. The result is registered on uo_out; exception flags are driven on uio_out[7:4].

Parameters:
- None. Format is fixed E4M3, bias 7.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  tile enable; when 0, commands are ignored and state holds.
- ui_in  in  8  data byte (operand value for load commands).
- uio_in  in  8  [1:0] cmd (00 NOP, 01 LOAD_A, 10 LOAD_B, 11 EXEC); [3:2] op (00 ADD, 01 SUB, 10 MUL, 11 MAX); [7:4] ignored.
- uo_out  out  8  result register.
- uio_out  out  8  [7] NV invalid, [6] OF overflow, [5] UF underflow, [4] NX inexact, [3:0] = 0.
- uio_oe  out  8  constant 8'hF0.

Behaviour:
- Reset (rst_n=0 at a clk edge): A, B, result and all four flags are cleared to 0. A reset mid-operation wins over any command in that cycle.
- Command sampling: commands are sampled only on the clk edge with ena=1 and rst_n=1.
- LOAD_A: A <= ui_in. LOAD_B: B <= ui_in. NOP: no change.
- EXEC: result and flags <= f(op, A, B), computed combinationally from the current A/B. Visible on uo_out/uio_out after that same edge (1-cycle latency).
- Back-to-back EXECs are allowed. Loads leave result and flags unchanged.
- Flags are per-operation, not sticky: each EXEC overwrites all four.
- Inputs with exponent 0 are treated as signed zero (flush-to-zero) unless FPU_SUBNORMAL_EN is defined.
- Rounding: round-to-nearest, ties-to-even on the 3-bit mantissa using guard/round/sticky bits. NX is set if any discarded bit is nonzero.
- Overflow: if the rounded magnitude exceeds 0x77 (240.0), the result is signed Inf (0x78|sign) with OF=1 and NX=1.
- Underflow: a nonzero result below 2^-6 (0x08) becomes signed zero with UF=1 and NX=1.
- NaN: any NaN input gives canonical NaN 0x7F with NV=0. Exception: MAX returns the non-NaN operand, or 0x7F if both are NaN.
- ADD/SUB: SUB flips the sign of B, then adds.
  - Align by exponent difference; shift-out bits feed sticky.
  - Add or subtract the 1.3 significands, then normalize with a leading-zero shift.
  - An exact zero sum gives +0; the exception is (-0)+(-0), which gives -0.
  - Inf + finite = Inf. Inf + (-Inf) gives 0x7F with NV=1.
- MUL: sign = XOR of operand signs. Exponent = eA+eB-7. Significand product is 4x4 bits = 8 bits; normalize by 1 and round.
  - 0 x Inf gives 0x7F with NV=1.
  - Inf x finite nonzero = signed Inf.
  - 0 x finite = signed zero.
- MAX: IEEE maxNum-style. Ordered compare on sign-magnitude; max(+0,-0)=+0. Flags are always 0 except in the NaN rule above.

Optional Feature:
- Macro: FPU_SUBNORMAL_EN.
- Defined:
  - Exponent-0 inputs are subnormals with value 0.m x 2^-6.
  - Tiny results are denormalized and rounded RNE into the subnormal range. They become zero only if they round below 2^-9.
  - UF=1 only when the result is tiny and inexact.
- Undefined: flush-to-zero on inputs and outputs as described in Behaviour.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0xF0.
- LOAD_A 0x38, LOAD_B 0x38, EXEC ADD -> uo_out=0x40 next cycle, flags 0000. Repeat with ena=0 on the EXEC -> outputs unchanged.
- Rounding with A=0x38: B=0x1C ADD -> 0x39, NX=1. B=0x18 ADD (tie) -> 0x38, NX=1. A=0x3C, B=0x3C MUL -> 0x41, flags 0000.
- Overflow and invalid: A=0x77, B=0x40 MUL -> 0x78, OF=1, NX=1. A=0x78, B=0x78 SUB -> 0x7F, NV=1. A=0x00, B=0xF8 MUL -> 0x7F, NV=1.
- Underflow: A=0x08, B=0x30 MUL -> 0x00 with UF=1, NX=1; with FPU_SUBNORMAL_EN -> 0x04, flags 0000.
- MAX: A=0x80, B=0x00 -> 0x00. A=0x7F, B=0xC0 -> 0xC0. A=0xB8, B=0x38 -> 0x38. All flags 0.
